// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state type for the UART receiver
package uart_pkg;

  // 50 MHz clock, 19200 baud
  localparam int BAUD_DIV_DEFAULT = 2604;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    BREAK   = 2'd2
  } rcv_state_e;

endpackage

// File: rtl/uart_sync2.sv
// rtl/uart_sync2.sv - two-flop synchronizer, both stages preset to 1 (idle line)
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/uart_rcv.sv
// rtl/uart_rcv.sv - 8N1 UART receiver with ready/ack handshake, framing and overrun flags
module uart_rcv
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       frm_err,
  output logic       ovr_err
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  rcv_state_e    state;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic          RX_s;
  logic          sample;
  logic          false_start;
  logic          frame_done;
  logic          unused_start_bit;

  uart_sync2 u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (RX),
    .sync_out (RX_s)
  );

  assign sample      = (state == RECEIVE) && (baud_cnt == '0);
  assign false_start = sample && (bit_cnt == 4'd0) && RX_s;
  assign frame_done  = sample && (bit_cnt == 4'd9);

  // The start bit ends up in shreg[0] at frame completion and is never needed.
  assign unused_start_bit = shreg[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!RX_s) begin
            state    <= RECEIVE;
            baud_cnt <= HALF_LOAD;
            bit_cnt  <= 4'd0;
          end
        end
        RECEIVE: begin
          if (sample) begin
            shreg    <= {RX_s, shreg[8:1]};
            baud_cnt <= FULL_LOAD;
            bit_cnt  <= bit_cnt + 4'd1;
            if (false_start) begin
              state <= IDLE;
            end else if (frame_done) begin
              state <= RX_s ? IDLE : BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_ONE;
          end
        end
        BREAK: begin
          if (RX_s) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A completing frame wins over an acknowledge on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data <= 8'h00;
      rdy     <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
    end else if (frame_done) begin
      rx_data <= shreg[8:1];
      rdy     <= 1'b1;
      frm_err <= ~RX_s;
      ovr_err <= clr_rdy ? 1'b0 : (ovr_err | rdy);
    end else if (clr_rdy) begin
      rdy     <= 1'b0;
      ovr_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rcv.sv
// tb/tb_uart_rcv.sv - directed bench for uart_rcv at full and reduced baud divisors
module tb_uart_rcv;
  import uart_pkg::*;

  localparam int SLOW_DIV = 2604;
  localparam int FAST_DIV = 20;

  logic       clk;
  logic       rst;
  logic       rx_a, clr_a, rx_b, clr_b;
  logic [7:0] data_a, data_b;
  logic       rdy_a, frm_a, ovr_a;
  logic       rdy_b, frm_b, ovr_b;
  int         checks   = 0;
  int         failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  uart_rcv u_slow (
    .clk     (clk),
    .rst     (rst),
    .RX      (rx_a),
    .clr_rdy (clr_a),
    .rx_data (data_a),
    .rdy     (rdy_a),
    .frm_err (frm_a),
    .ovr_err (ovr_a)
  );

  uart_rcv #(.BAUD_DIV(FAST_DIV)) u_fast (
    .clk     (clk),
    .rst     (rst),
    .RX      (rx_b),
    .clr_rdy (clr_b),
    .rx_data (data_b),
    .rdy     (rdy_b),
    .frm_err (frm_b),
    .ovr_err (ovr_b)
  );

  // Callers start these on a falling edge; they also end on one.
  task automatic tx_a(input logic [7:0] d, input logic stop);
    rx_a = 1'b0;
    repeat (SLOW_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_a = d[i];
      repeat (SLOW_DIV) @(negedge clk);
    end
    rx_a = stop;
    repeat (SLOW_DIV) @(negedge clk);
  endtask

  task automatic tx_b(input logic [7:0] d, input logic stop);
    rx_b = 1'b0;
    repeat (FAST_DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_b = d[i];
      repeat (FAST_DIV) @(negedge clk);
    end
    rx_b = stop;
    repeat (FAST_DIV) @(negedge clk);
  endtask

  task automatic pulse_clr_b();
    clr_b = 1'b1;
    @(negedge clk);
    clr_b = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_a = 1'b1; rx_b = 1'b1; clr_a = 1'b0; clr_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (data_a !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", data_a); end
    checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL reset_rdy: got %b want 0", rdy_a); end
    checks++; if (frm_a !== 1'b0) begin failures++; $display("FAIL reset_frm: got %b want 0", frm_a); end
    checks++; if (ovr_a !== 1'b0) begin failures++; $display("FAIL reset_ovr: got %b want 0", ovr_a); end
    checks++; if (u_slow.state !== IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", u_slow.state, IDLE); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_frame_timing();
    @(negedge clk);
    fork
      tx_a(8'hA5, 1'b1);
      begin
        repeat (3) @(posedge clk);
        repeat (24737) @(posedge clk);
        #1;
        checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL a5_early_rdy: got %b want 0", rdy_a); end
        @(posedge clk);
        #1;
        checks++; if (rdy_a !== 1'b1) begin failures++; $display("FAIL a5_rdy: got %b want 1", rdy_a); end
        checks++; if (data_a !== 8'hA5) begin failures++; $display("FAIL a5_data: got %h want a5", data_a); end
        checks++; if (frm_a !== 1'b0) begin failures++; $display("FAIL a5_frm: got %b want 0", frm_a); end
        checks++; if (ovr_a !== 1'b0) begin failures++; $display("FAIL a5_ovr: got %b want 0", ovr_a); end
      end
    join
    clr_a = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL a5_clr_rdy: got %b want 0", rdy_a); end
    checks++; if (data_a !== 8'hA5) begin failures++; $display("FAIL a5_clr_data: got %h want a5", data_a); end
    @(negedge clk);
    clr_a = 1'b0;
  endtask

  task automatic test_glitch();
    @(negedge clk);
    rx_a = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (u_slow.state !== RECEIVE) begin failures++; $display("FAIL glitch_recv: got %0d want %0d", u_slow.state, RECEIVE); end
    repeat (200) @(negedge clk);
    rx_a = 1'b1;
    repeat (1500) @(negedge clk);
    checks++; if (u_slow.state !== IDLE) begin failures++; $display("FAIL glitch_idle: got %0d want %0d", u_slow.state, IDLE); end
    checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL glitch_rdy: got %b want 0", rdy_a); end
    checks++; if (data_a !== 8'hA5) begin failures++; $display("FAIL glitch_data: got %h want a5", data_a); end
  endtask

  task automatic test_break();
    @(negedge clk);
    tx_b(8'h3C, 1'b0);
    repeat (2) @(negedge clk);
    checks++; if (data_b !== 8'h3C) begin failures++; $display("FAIL brk_data: got %h want 3c", data_b); end
    checks++; if (rdy_b !== 1'b1) begin failures++; $display("FAIL brk_rdy: got %b want 1", rdy_b); end
    checks++; if (frm_b !== 1'b1) begin failures++; $display("FAIL brk_frm: got %b want 1", frm_b); end
    checks++; if (u_fast.state !== BREAK) begin failures++; $display("FAIL brk_state: got %0d want %0d", u_fast.state, BREAK); end
    repeat (10000) @(negedge clk);
    checks++; if (u_fast.state !== BREAK) begin failures++; $display("FAIL brk_hold: got %0d want %0d", u_fast.state, BREAK); end
    checks++; if (data_b !== 8'h3C) begin failures++; $display("FAIL brk_hold_data: got %h want 3c", data_b); end
    rx_b = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (u_fast.state !== IDLE) begin failures++; $display("FAIL brk_exit: got %0d want %0d", u_fast.state, IDLE); end
    pulse_clr_b();
    checks++; if (rdy_b !== 1'b0) begin failures++; $display("FAIL brk_clr_rdy: got %b want 0", rdy_b); end
    checks++; if (frm_b !== 1'b1) begin failures++; $display("FAIL brk_clr_frm: got %b want 1", frm_b); end
    tx_b(8'h01, 1'b1);
    checks++; if (data_b !== 8'h01) begin failures++; $display("FAIL next_data: got %h want 01", data_b); end
    checks++; if (frm_b !== 1'b0) begin failures++; $display("FAIL next_frm: got %b want 0", frm_b); end
    checks++; if (rdy_b !== 1'b1) begin failures++; $display("FAIL next_rdy: got %b want 1", rdy_b); end
  endtask

  task automatic test_overrun();
    pulse_clr_b();
    tx_b(8'h11, 1'b1);
    checks++; if (data_b !== 8'h11) begin failures++; $display("FAIL ovr_first_data: got %h want 11", data_b); end
    checks++; if (ovr_b !== 1'b0) begin failures++; $display("FAIL ovr_first_ovr: got %b want 0", ovr_b); end
    tx_b(8'h22, 1'b1);
    checks++; if (data_b !== 8'h22) begin failures++; $display("FAIL ovr_data: got %h want 22", data_b); end
    checks++; if (rdy_b !== 1'b1) begin failures++; $display("FAIL ovr_rdy: got %b want 1", rdy_b); end
    checks++; if (ovr_b !== 1'b1) begin failures++; $display("FAIL ovr_flag: got %b want 1", ovr_b); end
    pulse_clr_b();
    checks++; if (rdy_b !== 1'b0) begin failures++; $display("FAIL ovr_clr_rdy: got %b want 0", rdy_b); end
    checks++; if (ovr_b !== 1'b0) begin failures++; $display("FAIL ovr_clr_ovr: got %b want 0", ovr_b); end
  endtask

  task automatic test_clr_on_stop();
    tx_b(8'h44, 1'b1);
    fork
      tx_b(8'h66, 1'b1);
      begin
        repeat (3) @(posedge clk);
        repeat (FAST_DIV / 2 + 9 * FAST_DIV - 1) @(posedge clk);
        #1;
        checks++; if (data_b !== 8'h44) begin failures++; $display("FAIL cos_before: got %h want 44", data_b); end
        @(negedge clk);
        clr_b = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (rdy_b !== 1'b1) begin failures++; $display("FAIL cos_rdy: got %b want 1", rdy_b); end
        checks++; if (ovr_b !== 1'b0) begin failures++; $display("FAIL cos_ovr: got %b want 0", ovr_b); end
        checks++; if (data_b !== 8'h66) begin failures++; $display("FAIL cos_data: got %h want 66", data_b); end
        @(negedge clk);
        clr_b = 1'b0;
      end
    join
    checks++; if (rdy_b !== 1'b1) begin failures++; $display("FAIL cos_after_rdy: got %b want 1", rdy_b); end
    checks++; if (ovr_b !== 1'b0) begin failures++; $display("FAIL cos_after_ovr: got %b want 0", ovr_b); end
  endtask

  task automatic test_reset_mid_frame();
    @(negedge clk);
    fork
      tx_b(8'hFF, 1'b1);
      begin
        repeat (3) @(posedge clk);
        repeat (FAST_DIV / 2 + 4 * FAST_DIV + 3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (rdy_b !== 1'b0) begin failures++; $display("FAIL rst_rdy: got %b want 0", rdy_b); end
        checks++; if (data_b !== 8'h00) begin failures++; $display("FAIL rst_data: got %h want 00", data_b); end
        checks++; if (u_fast.state !== IDLE) begin failures++; $display("FAIL rst_state: got %0d want %0d", u_fast.state, IDLE); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
      end
    join
    repeat (FAST_DIV * 2) @(negedge clk);
    checks++; if (rdy_b !== 1'b0) begin failures++; $display("FAIL rst_partial_rdy: got %b want 0", rdy_b); end
    tx_b(8'h5A, 1'b1);
    checks++; if (data_b !== 8'h5A) begin failures++; $display("FAIL post_rst_data: got %h want 5a", data_b); end
    checks++; if (rdy_b !== 1'b1) begin failures++; $display("FAIL post_rst_rdy: got %b want 1", rdy_b); end
    checks++; if (frm_b !== 1'b0) begin failures++; $display("FAIL post_rst_frm: got %b want 0", frm_b); end
    checks++; if (ovr_b !== 1'b0) begin failures++; $display("FAIL post_rst_ovr: got %b want 0", ovr_b); end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_glitch();
    test_break();
    test_overrun();
    test_clr_on_stop();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rcv.md
UART_RCV -- requirements
Module: uart_rcv

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per bit period (50 MHz / 19200 baud).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 RX  input  1  asynchronous serial line; idle high; 8N1, LSB first.
REQ-005 clr_rdy  input  1  consumer acknowledge; clears rdy and ovr_err.
REQ-006 rx_data  output  8  last received byte.
REQ-007 rdy  output  1  byte available in rx_data.
REQ-008 frm_err  output  1  stop bit of last byte sampled low.
REQ-009 ovr_err  output  1  sticky; byte completed while rdy already high.

Function
REQ-010 RX SHALL pass through two flops, both preset to 1; only the second-stage output (RX_s) SHALL be used.
REQ-011 FSM states SHALL be IDLE, RECEIVE and BREAK.
REQ-012 IDLE: RX_s==0 SHALL move to RECEIVE, load baud_cnt with BAUD_DIV/2-1 and clear bit_cnt.
REQ-013 RECEIVE: baud_cnt SHALL decrement each clock; at 0 it SHALL sample RX_s into a 9-bit shift register (MSB in, shift right), reload BAUD_DIV-1 and increment bit_cnt.
REQ-014 A sample with bit_cnt==0 (start bit) that reads 1 SHALL be a false start: return to IDLE, no output change.
REQ-015 The sample at bit_cnt==9 (stop bit) SHALL complete the frame: rx_data <= data bits, rdy <= 1, frm_err <= ~stop bit, on that same edge.
REQ-016 Stop-bit sample SHALL occur 1302+9*2604 = 24738 clocks after the edge entering RECEIVE (BAUD_DIV=2604).
REQ-017 After a completed frame: stop bit 1 -> IDLE; stop bit 0 -> BREAK.
REQ-018 BREAK SHALL remain until RX_s==1, then go to IDLE; no start detection in BREAK.
REQ-019 Frame completion while rdy==1 and clr_rdy==0 SHALL set ovr_err; rx_data is overwritten.
REQ-020 clr_rdy==1 SHALL clear rdy and ovr_err on the next edge unless a frame completes on that edge.
REQ-021 Simultaneous clr_rdy and frame completion: rdy SHALL stay 1; ovr_err SHALL NOT be set.
REQ-022 frm_err SHALL change only at frame completion; clr_rdy SHALL NOT affect it.
REQ-023 baud_cnt and bit_cnt SHALL be held (no counting) outside RECEIVE.

Reset
REQ-024 rst SHALL asynchronously force state=IDLE, rx_data=8'h00, rdy=0, frm_err=0, ovr_err=0, synchronizer flops=1, counters=0.
REQ-025 rst asserted mid-frame SHALL discard the partial byte; after release the block SHALL wait for a new falling edge on RX_s.

Structure
REQ-026 Package uart_pkg SHALL hold the BAUD_DIV default constant and the receiver state enum typedef.
REQ-027 The two-flop synchronizer SHALL be a sub-module named uart_sync2 (reset-preset to 1).
REQ-028 All flops in uart_rcv SHALL use the same asynchronous active-high rst.

Verification
REQ-029 Drive 0xA5 framed 8N1 at 2604 clk/bit -> rdy=1, rx_data=8'hA5, frm_err=0 at 24738 clks after RECEIVE entry; clr_rdy pulse -> rdy=0 next edge.
REQ-030 Start-bit glitch: RX low for 500 clocks then high -> state returns to IDLE, rdy stays 0, rx_data unchanged.
REQ-031 Send 0x3C with stop bit 0, RX held low 10000 clocks then high -> rx_data=8'h3C, rdy=1, frm_err=1, FSM in BREAK until RX high; next frame 0x01 -> frm_err=0.
REQ-032 Send 0x11 then 0x22 without clr_rdy -> rx_data=8'h22, rdy=1, ovr_err=1; clr_rdy -> rdy=0, ovr_err=0.
REQ-033 clr_rdy asserted exactly on stop-sample edge of second byte -> rdy=1, ovr_err=0, rx_data=second byte.
REQ-034 Assert rst during bit 4 of 0xFF -> all outputs 0 immediately; subsequent clean 0x5A received correctly.
